// File: rtl/alu_bist_driver_pkg.sv
// alu_bist_driver_pkg: shared ALU op codes, BIST state encoding and vector record
package alu_bist_driver_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [3:0] NO_FAIL = 4'hF;
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;
endpackage

// File: rtl/alu_bist_rom.sv
// alu_bist_rom: fixed ALU test vectors with expected result and zero flag
module alu_bist_rom
    import alu_bist_driver_pkg::*;
(
    input  logic [2:0] idx,
    output vec_t       vec
);
    always_comb begin
        vec = '{ALU_OR, 32'h0, 32'h0, 32'h0, 1'b1};
        case (idx)
            3'd0: vec = '{ALU_ADD, 32'h5, 32'h3, 32'h8, 1'b0};
            3'd1: vec = '{ALU_SUB, 32'h7, 32'h7, 32'h0, 1'b1};
            3'd2: vec = '{ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1};
            3'd3: vec = '{ALU_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0};
            3'd4: vec = '{ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
            3'd5: vec = '{ALU_OR, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
            3'd6: vec = '{ALU_AND, 32'hAAAAAAAA, 32'h55555555, 32'h0, 1'b1};
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_bist_driver.sv
// alu_bist_driver: walks the vector table through the alu, counting mismatches
// and recording the first failing vector index.
module alu_bist_driver
    import alu_bist_driver_pkg::*;
#(
    parameter int NUM_VEC       = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] alu_input1,
    output logic [31:0] alu_input2,
    output logic [2:0]  ALUop,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_count,
    output logic [3:0]  first_fail_idx
);
    state_t     state, state_n;
    logic [2:0] idx;
    logic [3:0] cnt;
    vec_t       vec;
    logic       accept, last, miss;

    alu_bist_rom u_rom (.idx(idx), .vec(vec));

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = idx == 3'(NUM_VEC - 1);
    assign miss   = (alu_out != vec.res) || (alu_zero != vec.zero);
    assign busy   = state == DRIVE || state == SETTLE || state == CHECK;
    assign done   = state == DONE;
    assign pass   = done && err_count == 4'd0;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = accept ? DRIVE : state;
            DRIVE:      state_n = SETTLE;
            SETTLE:     state_n = cnt == 4'd0 ? CHECK : SETTLE;
            CHECK:      state_n = last ? DONE : DRIVE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_input1     <= '0;
            alu_input2     <= '0;
            ALUop          <= ALU_ADD;
            err_count      <= '0;
            first_fail_idx <= NO_FAIL;
            idx            <= '0;
            cnt            <= '0;
        end else begin
            if (accept) begin
                idx            <= '0;
                err_count      <= '0;
                first_fail_idx <= NO_FAIL;
            end
            if (state == DRIVE) begin
                alu_input1 <= vec.a;
                alu_input2 <= vec.b;
                ALUop      <= vec.op;
                cnt        <= 4'(SETTLE_CYCLES - 1);
            end
            if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == CHECK) begin
                if (miss) begin
                    err_count <= err_count + 4'(err_count != 4'hF);
                    if (err_count == 4'd0) first_fail_idx <= {1'b0, idx};
                end
                if (!last) idx <= idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_bist_driver.sv
// tb_alu_bist_driver: drives two BIST instances (default and 4-vector/3-settle)
// against a behavioural alu with injectable faults; scoreboard-checked.
module tb_alu_bist_driver;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sel = 1'b0;
    int          fault = 0;
    int          n_vec = 0, n_bad = 0;

    logic [31:0] in1_a, in2_a, out_a, in1_b, in2_b, out_b;
    logic [2:0]  op_a, op_b;
    logic        zero_a, zero_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0]  err_a, err_b, ffi_a, ffi_b;

    logic [2:0]  tv_op [8] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] tv_a  [8] = '{32'h5, 32'h7, 32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'h12340000, 32'hAAAAAAAA, 32'h0};
    logic [31:0] tv_b  [8] = '{32'h3, 32'h7, 32'h1, 32'h1, 32'h0FF00FF0, 32'h00005678, 32'h55555555, 32'h0};
    logic [31:0] tv_r  [8] = '{32'h8, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00F000F0, 32'h12345678, 32'h0, 32'h0};
    logic        tv_z  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic [66:0] vq [$];
    logic [39:0] rq [$];

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_m(input logic [2:0] op, input logic [31:0] a, b, input int fm);
        logic [31:0] r;
        r = op == 3'd0 ? a + b : op == 3'd1 ? (fm == 1 ? a + b : a - b) :
            op == 3'd2 ? a & b : op == 3'd3 ? a | b : 32'h0;
        return {r, fm == 2 ? 1'b0 : r == 32'h0};
    endfunction

    always_comb {out_a, zero_a} = alu_m(op_a, in1_a, in2_a, fault);
    always_comb {out_b, zero_b} = alu_m(op_b, in1_b, in2_b, fault);

    alu_bist_driver u_a (
        .clk(clk), .reset(reset), .start(start),
        .alu_input1(in1_a), .alu_input2(in2_a), .ALUop(op_a),
        .alu_out(out_a), .alu_zero(zero_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail_idx(ffi_a)
    );

    alu_bist_driver #(.NUM_VEC(4), .SETTLE_CYCLES(3)) u_b (
        .clk(clk), .reset(reset), .start(start),
        .alu_input1(in1_b), .alu_input2(in2_b), .ALUop(op_b),
        .alu_out(out_b), .alu_zero(zero_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail_idx(ffi_b)
    );

    wire [31:0] in1  = sel ? in1_b  : in1_a;
    wire [31:0] in2  = sel ? in2_b  : in2_a;
    wire [2:0]  op   = sel ? op_b   : op_a;
    wire        busy = sel ? busy_b : busy_a;
    wire        done = sel ? done_b : done_a;
    wire        pass = sel ? pass_b : pass_a;
    wire [3:0]  err  = sel ? err_b  : err_a;
    wire [3:0]  ffi  = sel ? ffi_b  : ffi_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_in1", in1, 32'h0);
        check("rst_in2", in2, 32'h0);
        check("rst_op", 32'(op), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ffi", 32'(ffi), 32'hF);
    endtask

    task automatic run(input int fm, input int poke);
        int p, n, lat, k;
        logic [3:0] e_err, e_ffi;
        logic [66:0] v;
        logic [39:0] r;
        p = sel ? 5 : 3;
        n = sel ? 4 : 8;
        fault = fm;
        e_err = 4'd0;
        e_ffi = 4'hF;
        for (int i = 0; i < n; i++) begin
            vq.push_back({tv_op[i], tv_a[i], tv_b[i]});
            if (alu_m(tv_op[i], tv_a[i], tv_b[i], fm) != {tv_r[i], tv_z[i]}) begin
                if (e_err == 4'd0) e_ffi = 4'(i);
                e_err = e_err + 4'd1;
            end
        end
        rq.push_back({e_err, e_ffi, 32'(n * p)});
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("acc_busy", 32'(busy), 32'h1);
        check("acc_done", 32'(done), 32'h0);
        check("acc_err", 32'(err), 32'h0);
        check("acc_ffi", 32'(ffi), 32'hF);
        lat = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
            if (!done) begin
                check("busy", 32'(busy), 32'h1);
                if ((lat - 1) % p == 0) begin
                    k = (lat - 1) / p;
                    if (vq.size() == 0) check("vq_empty", 32'(k), 32'hFFFFFFFF);
                    else begin
                        v = vq.pop_front();
                        check($sformatf("op%0d", k), 32'(op), 32'(v[66:64]));
                        check($sformatf("a%0d", k), in1, v[63:32]);
                        check($sformatf("b%0d", k), in2, v[31:0]);
                    end
                end
            end
        end
        start = 1'b0;
        r = rq.pop_front();
        check("latency", 32'(lat), r[31:0]);
        check("done", 32'(done), 32'h1);
        check("busy_end", 32'(busy), 32'h0);
        check("pass", 32'(pass), 32'(r[39:36] == 4'd0));
        check("err_count", 32'(err), 32'(r[39:36]));
        check("first_fail", 32'(ffi), 32'(r[35:32]));
        check("vq_left", 32'(vq.size()), 32'h0);
        vq.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        run(0, 0);
        run(1, 0);
        run(2, 0);
        // abort during vector 4 settle, then confirm a clean rerun
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        check("pre_rst_a", in1, 32'hF0F0F0F0);
        #2 reset = 1'b1;
        #1 check_reset_vals();
        @(negedge clk) reset = 1'b0;
        run(0, 0);
        run(1, 0);
        run(0, 5);
        sel = 1'b1;
        run(0, 0);
        run(1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Synthesizable built-in self-test initiator for the combinational alu. It drives alu_input1, alu_input2 and ALUop, and checks alu_out and alu_zero.
- It steps through a fixed vector table, lets the ALU settle, and compares the ALU response against the expected result and zero flag.
- It reports pass/fail, the number of failing vectors and the index of the first failure.
- It sits beside the alu in the P4 datapath and is enabled only in test mode by top-level muxing.

Parameters:
- NUM_VEC, 8, number of table vectors applied per run; legal range 1..8, since the table holds 8 entries.
- SETTLE_CYCLES, 1, cycles operands are held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request; honoured only in IDLE or DONE.
- alu_input1  output  32  operand A to alu; registered.
- alu_input2  output  32  operand B to alu; registered.
- ALUop  output  3  operation select to alu; registered.
- alu_out  input  32  ALU result under test.
- alu_zero  input  1  ALU zero flag under test.
- busy  output  1  high from the first cycle after an accepted start until DONE.
- done  output  1  level; high in DONE until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  4  number of mismatching vectors in the last run.
- first_fail_idx  output  4  index of the first mismatching vector; 4'hF if none.

Behaviour:
- Reset (async, any state, including mid-run):
  - state=IDLE.
  - alu_input1=0, alu_input2=0, ALUop=3'b000.
  - busy=0, done=0, pass=0, err_count=0, first_fail_idx=4'hF, idx=0, settle counter=0.
- States and transitions:
  - IDLE: start=1 moves to DRIVE. Also on this edge: idx<=0, err_count<=0, first_fail_idx<=4'hF, done<=0.
  - DRIVE (1 cycle): load operand and op registers from table[idx]. Settle counter <= SETTLE_CYCLES-1. Next state is SETTLE.
  - SETTLE: hold operands. If counter==0, go to CHECK; else decrement the counter.
  - CHECK (1 cycle): a mismatch is (alu_out != exp_result) OR (alu_zero != exp_zero), sampled this cycle.
    - On a mismatch: err_count++ (saturating at 4'hF). If err_count==0 before the increment, first_fail_idx<=idx.
    - If idx==NUM_VEC-1, go to DONE; else idx++ and go to DRIVE.
  - DONE: done=1, busy=0, pass=(err_count==0). Operands hold the last vector. start=1 restarts exactly as from IDLE.
- Handshake rules:
  - start is ignored in DRIVE, SETTLE and CHECK.
  - start held high continuously restarts once per DONE entry; it does not retrigger mid-run.
- Latency:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - With defaults, done rises 8*(1+2)=24 cycles after the edge that accepted start.
  - busy is high for the same 24 cycles.
- Width and arithmetic rules:
  - Comparisons are full 32-bit equality; there is no masking.
  - idx is 3 bits.
- Vector table (op, A, B, exp_result, exp_zero):
  - 0: ADD, 5, 3, 8, 0
  - 1: SUB, 7, 7, 0, 1
  - 2: ADD, FFFFFFFF, 1, 0, 1 (wrap, no overflow trap)
  - 3: SUB, 0, 1, FFFFFFFF, 0
  - 4: AND, F0F0F0F0, 0FF00FF0, 00F000F0, 0
  - 5: OR, 12340000, 00005678, 12345678, 0
  - 6: AND, AAAAAAAA, 55555555, 0, 1
  - 7: OR, 0, 0, 0, 1

Decomposition:
- Shared include alu_defs.vh holds:
  - ALUop encodings: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011.
  - The BIST state encodings IDLE/DRIVE/SETTLE/CHECK/DONE.
  - The first_fail_idx "none" code 4'hF.
- Sub-module alu_bist_rom: combinational table indexed by idx, returning {op, A, B, exp_result, exp_zero}. This keeps the FSM independent of vector content.

Test Plan:
1. Reset, then pulse start with a correct alu attached → busy high for 24 cycles, then done=1, pass=1, err_count=0, first_fail_idx=F.
2. Faulty alu model with SUB returning A+B → vectors 1 and 3 fail: err_count=2, first_fail_idx=1, pass=0.
3. Faulty model with alu_zero stuck at 0 → vectors 1, 2, 6, 7 fail: err_count=4, first_fail_idx=1.
4. Assert reset during vector 4 SETTLE → all outputs return to reset values immediately (async). A subsequent start gives a clean 24-cycle run with pass=1.
5. Pulse start at cycle 5 of a run and again in DONE → the first is ignored and the run completes at cycle 24. The second clears done and err_count on its accept edge and a new run starts.
6. SETTLE_CYCLES=3, NUM_VEC=4 → per-vector period 5 cycles, done after 20 cycles. The CHECK sample occurs 4 cycles after DRIVE loads operands.
